// File: rtl/posit_mul_arbiter_pkg.sv
// Shared types for the posit multiplier arbiter: FSM state and the
// {valid,id} tag that travels alongside each multiply.
package posit_arb_defines;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    FLUSHED = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } tag_t;

  localparam int unsigned STAT_W = 32;

endpackage

// File: rtl/posit_mul_arbiter_if.sv
// Requester-side bundle between the PE array and the multiplier arbiter.
//
// Handshake: a requester raises req_valid[i] with stable operands and
// holds both until the cycle in which req_valid[i] & req_ready[i] is
// high; that cycle is the accept. req_ready is at most one-hot.
// res_valid[i] is a single-cycle pulse with res_data broadcast to all
// requesters; there is no back-pressure on the result side.
interface posit_mul_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*NBITS-1:0] req_in1;
  logic [NREQ*NBITS-1:0] req_in2;
  logic [NREQ-1:0]       res_valid;
  logic [NBITS-1:0]      res_data;

  modport master (
    output req_valid, req_in1, req_in2,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_in1, req_in2,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/posit_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after the
// pointer (wrapping) wins. Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan NREQ positions starting at ptr; the first hit locks the result.
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/posit_mul_arbiter.sv
// Shares one fixed-latency posit multiplier among NREQ requesters.
// Round-robin grant, registered launch, a tag pipe that follows each
// multiply and steers its result back, plus flush/drain control.
// Optional per-requester statistics: define POSIT_ARB_STATS_EN.
module posit_mul_arbiter
  import posit_arb_defines::*;
#(
  parameter int NREQ        = 4,
  parameter int NBITS       = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  posit_mul_arbiter_if.slave pe,
  output logic               mul_start,
  output logic [NBITS-1:0]   mul_in1,
  output logic [NBITS-1:0]   mul_in2,
  input  logic               mul_done,
  input  logic [NBITS-1:0]   mul_result,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               idle,
  output logic               seq_err,
`ifdef POSIT_ARB_STATS_EN
  output logic [NREQ*STAT_W-1:0] stat_grants,
  output logic [NREQ*STAT_W-1:0] stat_stalls,
`endif
  output arb_state_t         state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MUL_LATENCY + 3);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q;
  logic [NREQ-1:0]  pick;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             grant_en;
  logic             accept;
  tag_t             launch_tag_q;
  tag_t             tag_q [MUL_LATENCY];
  tag_t             head;
  logic             hit;
  logic [NREQ-1:0]  res_onehot;
  logic [NREQ-1:0]  res_valid_q;
  logic [NBITS-1:0] res_data_q;
  logic [NBITS-1:0] in1_q, in2_q;
  logic [CW-1:0]    inflight_q;
  logic             seq_err_q;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (pe.req_valid),
    .ptr   (ptr_q),
    .grant (pick),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Grants are only offered while running and no flush is being requested.
  assign grant_en     = (state_q == RUN) && !flush_req;
  assign pe.req_ready = grant_en ? pick : '0;
  assign accept       = grant_en && gnt_any;

  // Oldest tag in the pipe lines up with the multiplier's mul_done.
  assign head = tag_q[MUL_LATENCY-1];
  assign hit  = mul_done && head.valid;

  // Steer a matched result to the requester named in its tag.
  always_comb begin
    res_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      res_onehot[i] = hit && (head.id == 3'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: drain on flush, park once empty, resume on release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (!flush_req) state_d = RUN;
               else if (inflight_q == '0) state_d = FLUSHED;
      FLUSHED: if (!flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Round-robin pointer moves past the winner; holds when nothing accepted.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else if (accept) ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Launch registers: start pulses one cycle after accept, operands hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      launch_tag_q <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
    end else begin
      launch_tag_q <= '{valid: accept, id: 3'(gnt_idx)};
      if (accept) begin
        in1_q <= pe.req_in1[gnt_idx*NBITS +: NBITS];
        in2_q <= pe.req_in2[gnt_idx*NBITS +: NBITS];
      end
    end
  end

  // Tag pipe: MUL_LATENCY stages fed by the launch tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < MUL_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= launch_tag_q;
      for (int s = 1; s < MUL_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Return path and sticky sequencing error (done/tag disagreement).
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= '0;
      res_data_q  <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      res_valid_q <= res_onehot;
      if (hit) res_data_q <= mul_result;
      if (mul_done != head.valid) seq_err_q <= 1'b1;
    end
  end

  // In-flight count: up on accept, down when a tag leaves the pipe head.
  always_ff @(posedge clk) begin
    if (reset) inflight_q <= '0;
    else begin
      unique case ({accept, head.valid})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign mul_start    = launch_tag_q.valid;
  assign mul_in1      = in1_q;
  assign mul_in2      = in2_q;
  assign pe.res_valid = res_valid_q;
  assign pe.res_data  = res_data_q;
  assign seq_err      = seq_err_q;
  assign idle         = (inflight_q == '0);
  assign flush_done   = (state_q == FLUSHED);
  assign state_dbg    = state_q;

`ifdef POSIT_ARB_STATS_EN
  logic [NREQ*STAT_W-1:0] grants_q, stalls_q;

  // Saturating per-requester accept and stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (pe.req_valid[i] && pe.req_ready[i] &&
            grants_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})
          grants_q[i*STAT_W +: STAT_W] <= grants_q[i*STAT_W +: STAT_W] + 1'b1;
        if (pe.req_valid[i] && !pe.req_ready[i] &&
            stalls_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})
          stalls_q[i*STAT_W +: STAT_W] <= stalls_q[i*STAT_W +: STAT_W] + 1'b1;
      end
    end
  end

  assign stat_grants = grants_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Bench for posit_mul_arbiter: random requester traffic, a latency-4
// multiplier stand-in, a reference model of grant order / FSM / in-flight
// count, and a scoreboard that matches each returned result.
module tb_posit_mul_arbiter;
  import posit_arb_defines::*;

  localparam int NR = 4;
  localparam int L  = 4;
  localparam int EW = 67;  // {accept cycle[31:0], id[2:0], product[31:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic inject = 1'b0;
  logic mul_start, mul_done = 1'b0;
  logic [31:0] mul_in1, mul_in2, mul_result = '0;
  logic flush_done, idle, seq_err;
  arb_state_t state_dbg;
`ifdef POSIT_ARB_STATS_EN
  logic [NR*32-1:0] stat_grants, stat_stalls;
  longint m_gr [NR];
  longint m_st [NR];
`endif

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q [$];
  int acc_hist [$];
  int m_state = 0;
  int m_ptr = 0;
  bit m_seq = 0;
  bit m_ok = 0;

  posit_mul_arbiter_if #(.NREQ(NR), .NBITS(32)) pe ();

  posit_mul_arbiter #(.NREQ(NR), .NBITS(32), .MUL_LATENCY(L)) dut (
    .clk        (clk),
    .reset      (rst),
    .pe         (pe),
    .mul_start  (mul_start),
    .mul_in1    (mul_in1),
    .mul_in2    (mul_in2),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .flush_req  (flush),
    .flush_done (flush_done),
    .idle       (idle),
    .seq_err    (seq_err),
`ifdef POSIT_ARB_STATS_EN
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls),
`endif
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: exact for a 1.0 operand, otherwise a repeatable token.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000) return b;
    if (b == 32'h4000_0000) return a;
    return (a * b) ^ {b[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] rand_op();
    if ($urandom_range(3) == 0) return 32'h4000_0000;
    return $urandom();
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Fixed-latency multiplier model, cleared by the shared reset.
  logic [32:0] mpipe [0:L];
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k <= L; k++) mpipe[k] = '0;
      mul_done   = 1'b0;
      mul_result = '0;
    end else begin
      for (int k = L; k > 0; k--) mpipe[k] = mpipe[k-1];
      mpipe[0]   = {mul_start, mul_model(mul_in1, mul_in2)};
      mul_done   = mpipe[L][32] | inject;
      mul_result = mpipe[L][31:0];
    end
  end

  // ---------------- reference model + per-cycle checks ----------------
  always @(negedge clk) begin
    logic [3:0] er;
    int gi, infl;
    bit due, prev_acc;
    er = '0; gi = -1; infl = 0; due = 0; prev_acc = 0;
    if (rst) begin
      m_ok = 1; m_state = 0; m_ptr = 0; m_seq = 0;
      acc_hist.delete();
      exp_q.delete();
`ifdef POSIT_ARB_STATS_EN
      for (int i = 0; i < NR; i++) begin m_gr[i] = 0; m_st[i] = 0; end
`endif
    end else if (m_ok) begin
      foreach (acc_hist[j]) begin
        if (acc_hist[j] < cyc && cyc <= acc_hist[j] + L + 1) infl++;
        if (acc_hist[j] + L + 1 == cyc) due = 1;
        if (acc_hist[j] == cyc - 1) prev_acc = 1;
      end
      if (m_state == 0 && !flush)
        for (int k = 0; k < NR; k++)
          if (gi < 0 && pe.req_valid[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
      if (gi >= 0) er[gi] = 1'b1;

      chk("req_ready", 64'(pe.req_ready), 64'(er));
      chk("idle", 64'(idle), 64'(infl == 0));
      chk("flush_done", 64'(flush_done), 64'(m_state == 2));
      chk("seq_err", 64'(seq_err), 64'(m_seq));
      chk("mul_start", 64'(mul_start), 64'(prev_acc));
`ifdef POSIT_ARB_STATS_EN
      for (int i = 0; i < NR; i++) begin
        chk("stat_grants", 64'(stat_grants[i*32 +: 32]), 64'(m_gr[i]));
        chk("stat_stalls", 64'(stat_stalls[i*32 +: 32]), 64'(m_st[i]));
        if (er[i]) m_gr[i]++;
        else if (pe.req_valid[i]) m_st[i]++;
      end
`endif
      if (gi >= 0) begin
        exp_q.push_back({32'(cyc), 3'(gi),
                         mul_model(pe.req_in1[gi*32 +: 32], pe.req_in2[gi*32 +: 32])});
        acc_hist.push_back(cyc);
        m_ptr = (gi + 1) % NR;
      end
      if (inject && !due) m_seq = 1;
      case (m_state)
        0: if (flush) m_state = 1;
        1: if (!flush) m_state = 0; else if (infl == 0) m_state = 2;
        default: if (!flush) m_state = 0;
      endcase
      while (acc_hist.size() > 0 && acc_hist[0] + L + 1 < cyc) void'(acc_hist.pop_front());
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [3:0] oh;
    if (!rst && m_ok) begin
      if (pe.res_valid != '0) begin
        chk("res_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          oh = 4'b0001 << e[34:32];
          chk("res_valid_id", 64'(pe.res_valid), 64'(oh));
          chk("res_data", 64'(pe.res_data), 64'(e[31:0]));
          chk("res_latency", 64'(cyc), 64'(e[66:35] + 32'd6));
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][66:35]) + 6 < cyc) begin
        chk("res_missing", 64'(0), 64'(1));
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Holds each request until accepted; refills with probability prob (%).
  task automatic drive(input int n, input logic [3:0] mask, input int prob);
    logic [3:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = pe.req_valid & pe.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) pe.req_valid[i] = 1'b0;
        if (!pe.req_valid[i] && mask[i] && int'($urandom_range(99)) < prob) begin
          pe.req_valid[i]         = 1'b1;
          pe.req_in1[i*32 +: 32] = rand_op();
          pe.req_in2[i*32 +: 32] = rand_op();
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    pe.req_valid = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    pe.req_valid = '0;
    pe.req_in1   = '0;
    pe.req_in2   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single request from req0: 1.0 * x
    pe.req_valid[0]    = 1'b1;
    pe.req_in1[31:0]   = 32'h4000_0000;
    pe.req_in2[31:0]   = 32'h4800_0000;
    drive(10, 4'b0000, 0);

    // all requesters saturated: strict rotation
    drive(12, 4'b1111, 100);
    drive(8, 4'b0000, 0);

    // lone requester accepted every cycle
    drive(8, 4'b0100, 100);
    drive(8, 4'b0000, 0);

    // random traffic
    for (int r = 0; r < 4; r++) drive(10, 4'($urandom_range(15)), 50);

    // flush while busy, then release
    drive(4, 4'b1111, 100);
    flush = 1'b1;
    drive(12, 4'b1111, 100);
    flush = 1'b0;
    drive(8, 4'b1111, 60);
    drive(10, 4'b0000, 0);

    // reset with work in flight, then pointer restarts at req0
    drive(4, 4'b1111, 100);
    do_reset(2);
    drive(10, 4'b0000, 0);
    pe.req_valid = 4'b1111;
    drive(6, 4'b1111, 100);
    drive(10, 4'b0000, 0);

    // spurious multiplier done while empty
    inject = 1'b1;
    drive(1, 4'b0000, 0);
    inject = 1'b0;
    drive(6, 4'b0000, 0);

    // reset clears the sticky error
    do_reset(2);
    drive(4, 4'b0011, 100);
    drive(10, 4'b0000, 0);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
